// File: rtl/spram_pkg.sv
// Shared types and helpers for the SPRAM initiator: power states, macro address width
// and the byte-enable to nibble write-mask expansion.
package spram_pkg;

   typedef enum logic [1:0] {ACTIVE, STBY, SLEEP, WAKE} pwr_state_t;

   localparam int SPRAM_AW = 14;

   // MASKWE is one bit per nibble; each byte enable covers two nibbles. {hi[3:0], lo[3:0]}
   function automatic logic [7:0] be2mask(input logic [3:0] be);
      return {be[3], be[3], be[2], be[2], be[1], be[1], be[0], be[0]};
   endfunction

endpackage

// File: rtl/spram_pwr_fsm.sv
// SPRAM macro power sequencer: auto-standby after an idle run, software sleep,
// and a fixed wake-up delay before requests are accepted again.
module spram_pwr_fsm
   import spram_pkg::*;
#(
   parameter int IDLE_CYCLES = 64,
   parameter int WAKE_CYCLES = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic req_valid,
   input  logic req_fire,
   input  logic sleep_req,
   output logic stdby,
   output logic sleep,
   output logic ready_en
);

   localparam int ICW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
   localparam int WCW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
   localparam logic [ICW-1:0] IDLE_LAST = ICW'((IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0);
   localparam logic [WCW-1:0] WAKE_LAST = WCW'((WAKE_CYCLES > 0) ? WAKE_CYCLES - 1 : 0);

   pwr_state_t     state, state_nx;
   logic [ICW-1:0] idle_cnt, idle_nx;
   logic [WCW-1:0] wake_cnt, wake_nx;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ACTIVE;
         idle_cnt <= '0;
         wake_cnt <= '0;
      end else begin
         state    <= state_nx;
         idle_cnt <= idle_nx;
         wake_cnt <= wake_nx;
      end
   end

   always_comb begin
      state_nx = state;
      idle_nx  = idle_cnt;
      wake_nx  = '0;
      case (state)
         ACTIVE: begin
            // an accepted request wins over sleep; sleep is taken on the next idle cycle
            if (req_fire) begin
               idle_nx = '0;
            end else if (sleep_req) begin
               state_nx = SLEEP;
               idle_nx  = '0;
            end else if (IDLE_CYCLES != 0) begin
               if (idle_cnt == IDLE_LAST) begin
                  state_nx = STBY;
                  idle_nx  = '0;
               end else begin
                  idle_nx = idle_cnt + 1'b1;
               end
            end
         end
         STBY:  if (req_valid || sleep_req) state_nx = WAKE;
         SLEEP: if (!sleep_req) state_nx = WAKE;
         WAKE: begin
            if (wake_cnt == WAKE_LAST) state_nx = sleep_req ? SLEEP : ACTIVE;
            else                       wake_nx  = wake_cnt + 1'b1;
         end
         default: state_nx = ACTIVE;
      endcase
   end

   assign stdby    = (state == STBY);
   assign sleep    = (state == SLEEP);
   assign ready_en = (state == ACTIVE);

endmodule

// File: rtl/spram_ctrl.sv
// 32-bit valid/ready request port to BANKS pairs of iCE40UP 16Kx16 SPRAM macros,
// single-cycle issue, fixed 1-cycle read latency, with macro power management.
module spram_ctrl
   import spram_pkg::*;
#(
   parameter int BANKS       = 2,
   parameter int IDLE_CYCLES = 64,
   parameter int WAKE_CYCLES = 3
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                req_valid,
   output logic                                req_ready,
   input  logic                                req_we,
   input  logic [3:0]                          req_be,
   input  logic [SPRAM_AW+$clog2(BANKS)-1:0]   req_addr,
   input  logic [31:0]                         req_wdata,
   output logic                                rsp_valid,
   output logic [31:0]                         rsp_rdata,
   input  logic                                sleep_req,
   output logic [BANKS-1:0]                    spram_cs,
   output logic                                spram_we,
   output logic [SPRAM_AW-1:0]                 spram_ad,
   output logic [31:0]                         spram_di,
   output logic [3:0]                          spram_mask_lo,
   output logic [3:0]                          spram_mask_hi,
   input  logic [32*BANKS-1:0]                 spram_do,
   output logic                                spram_stdby,
   output logic                                spram_sleep,
   output logic                                spram_pwroff_n
);

   localparam int AW = SPRAM_AW + $clog2(BANKS);
   localparam int BW = (BANKS > 1) ? $clog2(BANKS) : 1;

   logic                   ready_en, req_fire, rd_fire, vld_q;
   logic [BW-1:0]          bank, bank_q;
   logic [7:0]             wmask;
   logic [BANKS-1:0][31:0] do_bank;
   logic [31:0]            do_sel, rdata_q;

   spram_pwr_fsm #(
      .IDLE_CYCLES(IDLE_CYCLES),
      .WAKE_CYCLES(WAKE_CYCLES)
   ) u_pwr (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_fire  (req_fire),
      .sleep_req (sleep_req),
      .stdby     (spram_stdby),
      .sleep     (spram_sleep),
      .ready_en  (ready_en)
   );

   assign req_ready = ready_en & ~rst;
   assign req_fire  = req_valid & req_ready;
   assign rd_fire   = req_fire & ~req_we;

   generate
      if (BANKS > 1) begin : g_bank
         assign bank = req_addr[AW-1:SPRAM_AW];
      end else begin : g_one
         assign bank = '0;
      end
   endgenerate

   always_comb begin
      spram_cs = '0;
      for (int b = 0; b < BANKS; b++) spram_cs[b] = req_fire && (bank == BW'(b));
   end

   // WE and masks are qualified by the accept so they idle low between requests
   assign spram_we       = req_fire & req_we;
   assign spram_ad       = req_addr[SPRAM_AW-1:0];
   assign spram_di       = req_wdata;
   assign wmask          = spram_we ? be2mask(req_be) : 8'h00;
   assign spram_mask_lo  = wmask[3:0];
   assign spram_mask_hi  = wmask[7:4];
   assign spram_pwroff_n = 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q   <= 1'b0;
         bank_q  <= '0;
         rdata_q <= '0;
      end else begin
         vld_q <= rd_fire;
         if (rd_fire)   bank_q  <= bank;
         if (rsp_valid) rdata_q <= do_sel;
      end
   end

   // macro DO is already registered, so the response is a mux of the captured bank
   assign do_bank   = spram_do;
   assign do_sel    = do_bank[bank_q];
   assign rsp_valid = vld_q & ~rst;
   assign rsp_rdata = rsp_valid ? do_sel : rdata_q;

endmodule

// File: tb/tb_spram_ctrl.sv
// Bench for spram_ctrl: SPRAM macro models on the strobe side, a word/byte-level
// reference model of memory and power timing, directed literal checks plus random traffic.
`timescale 1ns/1ps
module tb_spram_ctrl;

   localparam int BANKS = 2;
   localparam int IDLE  = 4;
   localparam int WAKE  = 3;
   localparam int AW    = 15;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic                   req_valid = 1'b0, req_we = 1'b0, sleep_req = 1'b0;
   logic [3:0]             req_be = 4'h0;
   logic [AW-1:0]          req_addr = '0;
   logic [31:0]            req_wdata = '0;
   logic                   req_ready, rsp_valid, spram_we, spram_stdby, spram_sleep, spram_pwroff_n;
   logic [31:0]            rsp_rdata, spram_di;
   logic [BANKS-1:0]       spram_cs;
   logic [13:0]            spram_ad;
   logic [3:0]             spram_mask_lo, spram_mask_hi;
   logic [BANKS-1:0][31:0] mac_do = '0;

   int n_cmp = 0;
   int n_bad = 0;

   spram_ctrl #(.BANKS(BANKS), .IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata), .sleep_req(sleep_req), .spram_cs(spram_cs), .spram_we(spram_we),
      .spram_ad(spram_ad), .spram_di(spram_di), .spram_mask_lo(spram_mask_lo),
      .spram_mask_hi(spram_mask_hi), .spram_do(mac_do), .spram_stdby(spram_stdby),
      .spram_sleep(spram_sleep), .spram_pwroff_n(spram_pwroff_n)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // SPRAM macros: nibble-masked writes, registered DO on read
   logic [31:0] mac [int];
   always @(posedge clk) begin
      for (int b = 0; b < BANKS; b++) begin
         if (spram_cs[b]) begin
            int k;
            logic [31:0] w;
            k = b * 16384 + int'(spram_ad);
            w = mac.exists(k) ? mac[k] : 32'h0;
            if (spram_we) begin
               for (int n = 0; n < 8; n++)
                  if ((n < 4) ? spram_mask_lo[n] : spram_mask_hi[n-4]) w[4*n +: 4] = spram_di[4*n +: 4];
               mac[k] = w;
            end else begin
               mac_do[b] <= w;
            end
         end
      end
   end

   // reference model: byte-addressed word store, expected response, power timing
   localparam int M_ACT = 0, M_STBY = 1, M_SLEEP = 2, M_WAKE = 3;
   logic [31:0] ref_mem [int];
   int          pmode = M_ACT, idle_n = 0, wake_left = 0;
   bit          started = 0, exp_v = 0;
   logic [31:0] exp_d = '0, hold = '0;

   always @(posedge clk) begin
      bit acc;
      int a;
      logic [31:0] w;
      if (rst) begin
         pmode = M_ACT; idle_n = 0; exp_v = 0; hold = '0; started = 1;
      end else if (started) begin
         acc = req_valid && (pmode == M_ACT);
         if (exp_v) hold = exp_d;
         exp_v = 0;
         a = int'(req_addr);
         if (acc && req_we) begin
            w = ref_mem.exists(a) ? ref_mem[a] : 32'h0;
            for (int k = 0; k < 4; k++) if (req_be[k]) w[8*k +: 8] = req_wdata[8*k +: 8];
            ref_mem[a] = w;
         end else if (acc) begin
            exp_v = 1;
            exp_d = ref_mem.exists(a) ? ref_mem[a] : 32'h0;
         end
         case (pmode)
            M_ACT: begin
               if (acc) idle_n = 0;
               else if (sleep_req) pmode = M_SLEEP;
               else begin
                  idle_n++;
                  if (idle_n == IDLE) begin pmode = M_STBY; idle_n = 0; end
               end
            end
            M_STBY:  if (req_valid || sleep_req) begin pmode = M_WAKE; wake_left = WAKE; end
            M_SLEEP: if (!sleep_req) begin pmode = M_WAKE; wake_left = WAKE; end
            default: begin
               wake_left--;
               if (wake_left == 0) begin pmode = sleep_req ? M_SLEEP : M_ACT; idle_n = 0; end
            end
         endcase
      end
   end

   // per-cycle compare against the model
   always @(negedge clk) begin
      bit acc;
      logic [7:0] em;
      if (started) begin
         if (rst) begin
            chk("rst_ready", {31'b0, req_ready}, 32'd0);
            chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
            chk("rst_cs", {30'b0, spram_cs}, 32'd0);
         end else begin
            acc = req_valid && (pmode == M_ACT);
            chk("ready", {31'b0, req_ready}, {31'b0, pmode == M_ACT});
            chk("stdby", {31'b0, spram_stdby}, {31'b0, pmode == M_STBY});
            chk("sleep", {31'b0, spram_sleep}, {31'b0, pmode == M_SLEEP});
            chk("pwroff_n", {31'b0, spram_pwroff_n}, 32'd1);
            chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_v});
            chk("rsp_rdata", rsp_rdata, exp_v ? exp_d : hold);
            chk("cs", {30'b0, spram_cs}, acc ? (req_addr[14] ? 32'd2 : 32'd1) : 32'd0);
            if (acc) begin
               for (int k = 0; k < 8; k++) em[k] = req_we && req_be[k/2];
               chk("ad", {18'b0, spram_ad}, {18'b0, req_addr[13:0]});
               chk("we", {31'b0, spram_we}, {31'b0, req_we});
               chk("di", spram_di, req_wdata);
               chk("mask_lo", {28'b0, spram_mask_lo}, {28'b0, em[3:0]});
               chk("mask_hi", {28'b0, spram_mask_hi}, {28'b0, em[7:4]});
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic we, input logic [3:0] be, input logic [AW-1:0] a, input logic [31:0] d);
      int n;
      n = 0;
      req_valid = 1'b1; req_we = we; req_be = be; req_addr = a; req_wdata = d;
      @(negedge clk);
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) chk("accept_timeout", {31'b0, req_ready}, 32'd1);
      tick();
      req_valid = 1'b0;
   endtask

   task automatic read_chk(input logic [AW-1:0] a, input logic [31:0] exp);
      issue(1'b0, 4'h0, a, 32'h0);
      @(negedge clk);
      chk("lit_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("lit_rdata", rsp_rdata, exp);
      tick();
      @(negedge clk);
      chk("lit_rsp_drop", {31'b0, rsp_valid}, 32'd0);
      tick();
   endtask

   task automatic wake_count(output int n);
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 20) begin
         n++;
         @(negedge clk);
      end
   endtask

   initial begin
      int n;
      repeat (3) tick();
      @(negedge clk);
      chk("reset_ready", {31'b0, req_ready}, 32'd0);
      chk("reset_rsp", {31'b0, rsp_valid}, 32'd0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("post_reset_ready", {31'b0, req_ready}, 32'd1);
      chk("post_reset_rdata", rsp_rdata, 32'd0);
      chk("post_reset_stdby", {30'b0, spram_stdby, spram_sleep}, 32'd0);
      tick();

      issue(1'b1, 4'hF, 15'h0010, 32'hDEADBEEF);
      read_chk(15'h0010, 32'hDEADBEEF);

      issue(1'b1, 4'hF, 15'h0020, 32'h11223344);
      issue(1'b1, 4'h5, 15'h0020, 32'hAABBCCDD);
      read_chk(15'h0020, 32'h11BB33DD);
      issue(1'b1, 4'h0, 15'h0020, 32'hFFFFFFFF);
      read_chk(15'h0020, 32'h11BB33DD);

      issue(1'b1, 4'hF, 15'h4000, 32'hCAFE0001);
      issue(1'b1, 4'hF, 15'h0000, 32'h0BAD0002);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 15'h4000;
      @(negedge clk);
      chk("b2b_cs1", {30'b0, spram_cs}, 32'd2);
      tick();
      req_addr = 15'h0000;
      @(negedge clk);
      chk("b2b_cs0", {30'b0, spram_cs}, 32'd1);
      chk("b2b_rd1", rsp_rdata, 32'hCAFE0001);
      tick();
      req_valid = 1'b0;
      @(negedge clk);
      chk("b2b_rd0_valid", {31'b0, rsp_valid}, 32'd1);
      chk("b2b_rd0", rsp_rdata, 32'h0BAD0002);
      tick();

      issue(1'b1, 4'hF, 15'h0030, 32'h12345678);
      repeat (IDLE) begin
         @(negedge clk);
         chk("idle_no_stdby", {31'b0, spram_stdby}, 32'd0);
      end
      @(negedge clk);
      chk("idle_stdby", {31'b0, spram_stdby}, 32'd1);
      chk("idle_not_ready", {31'b0, req_ready}, 32'd0);
      tick();
      req_valid = 1'b1; req_we = 1'b0; req_addr = 15'h0010;
      wake_count(n);
      chk("stdby_wake_stall", n, 1 + WAKE);
      tick();
      req_valid = 1'b0;
      @(negedge clk);
      chk("stdby_rd", rsp_rdata, 32'hDEADBEEF);
      tick();

      sleep_req = 1'b1;
      @(negedge clk);
      tick();
      @(negedge clk);
      chk("sleep_on", {31'b0, spram_sleep}, 32'd1);
      chk("sleep_not_ready", {31'b0, req_ready}, 32'd0);
      repeat (3) tick();
      sleep_req = 1'b0;
      wake_count(n);
      chk("sleep_wake_stall", n, 1 + WAKE);
      tick();
      read_chk(15'h4000, 32'hCAFE0001);
      read_chk(15'h0020, 32'h11BB33DD);

      issue(1'b0, 4'h0, 15'h0010, 32'h0);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_squash", {31'b0, rsp_valid}, 32'd0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_after_ready", {31'b0, req_ready}, 32'd1);
      chk("rst_after_pwr", {30'b0, spram_stdby, spram_sleep}, 32'd0);
      chk("rst_after_rsp", {31'b0, rsp_valid}, 32'd0);
      tick();

      for (int blk = 0; blk < 8; blk++) begin
         int dens;
         dens = (blk % 2 == 1) ? 8 : 60;
         repeat (500) begin
            req_valid = ($urandom % 100) < dens;
            req_we    = $urandom % 2;
            req_be    = 4'($urandom);
            req_addr  = {1'($urandom), 10'b0, 4'($urandom)};
            req_wdata = $urandom;
            if ($urandom % 40 == 0) sleep_req = ~sleep_req;
            rst = ($urandom % 400 == 0);
            tick();
         end
      end
      rst = 1'b0; sleep_req = 1'b0; req_valid = 1'b0;
      repeat (10) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/spram_ctrl.md
Name: spram_ctrl

Overview:
- Initiator side of the iCE40UP single-port RAM macro interface.
- Turns a 32-bit valid/ready memory request port (CPU data/instruction side) into CS/WE/MASKWE/AD/DI strobes for BANKS pairs of 16Kx16 SPRAMs (lo/hi halfword per pair).
- Returns read data with fixed latency.
- Manages macro power: automatic standby after idle, plus software-requested sleep.

Parameters:
- BANKS, 2, number of SPRAM pairs (1 or 2); capacity = BANKS x 64 KB.
- IDLE_CYCLES, 64, consecutive idle cycles in ACTIVE before entering STBY; 0 disables auto-standby.
- WAKE_CYCLES, 3, cycles spent in WAKE after STDBY/SLEEP deassert before accepting requests (>=1).

Ports:
- clk  in  1  system clock, also drives every SPRAM CK
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted when valid & ready
- req_we  in  1  1 = write, 0 = read
- req_be  in  4  byte enables, bit n = byte n
- req_addr  in  14+clog2(BANKS)  32-bit word address; MSB(s) select bank
- req_wdata  in  32  write data
- rsp_valid  out  1  read data valid (single-cycle pulse, no backpressure)
- rsp_rdata  out  32  read data
- sleep_req  in  1  level; requests SLEEP state
- spram_cs  out  BANKS  per-bank chip select
- spram_we  out  1  shared WE
- spram_ad  out  14  shared address
- spram_di  out  32  {hi DI, lo DI}
- spram_mask_lo  out  4  MASKWE for lo-halfword macros
- spram_mask_hi  out  4  MASKWE for hi-halfword macros
- spram_do  in  32*BANKS  {hi DO, lo DO} per bank, bank 0 in LSBs
- spram_stdby  out  1  STDBY to all macros
- spram_sleep  out  1  SLEEP to all macros
- spram_pwroff_n  out  1  tied 1 (power never removed; contents retained)

Behaviour:
- Reset values:
  - state=ACTIVE; idle counter=0.
  - req_ready=0 during rst, 1 on the first cycle after.
  - rsp_valid=0; rsp_rdata=0.
  - spram_cs=0, spram_we=0, spram_stdby=0, spram_sleep=0, spram_pwroff_n=1.
- States:
  - ACTIVE: req_ready=1.
  - STBY: STDBY=1, req_ready=0.
  - SLEEP: SLEEP=1, req_ready=0.
  - WAKE: STDBY=SLEEP=0, req_ready=0, counts WAKE_CYCLES.
- Transitions:
  - ACTIVE->SLEEP when sleep_req=1 and no request accepted this cycle.
  - ACTIVE->STBY when idle counter reaches IDLE_CYCLES (counter resets on any accepted request).
  - STBY->WAKE when req_valid=1 or sleep_req=1. In the sleep_req case, WAKE then exits to SLEEP.
  - SLEEP->WAKE when sleep_req=0.
  - WAKE->ACTIVE after WAKE_CYCLES (or ->SLEEP if sleep_req=1).
- Request issue:
  - SPRAM strobes are combinational from the request during the accept cycle (cycle N).
  - spram_cs[bank]=valid & ready, spram_ad=req_addr[13:0], spram_we=req_we, spram_di=req_wdata.
  - Non-selected banks: CS=0.
- Write masks, each 1 bit per nibble:
  - mask_lo = {be[1],be[1],be[0],be[0]}.
  - mask_hi = {be[3],be[3],be[2],be[2]}.
  - Masks are 0 on reads.
  - A write with be=0 is accepted and leaves the array unchanged.
- Read latency:
  - Macro DO is valid at N+1.
  - Bank select is registered at N.
  - rsp_valid=1 at N+1; rsp_rdata = selected bank DO (combinational mux of the registered select) while rsp_valid.
  - rsp_rdata holds its last value otherwise (hold register).
  - Back-to-back reads every cycle sustain 1 result per cycle.
- Writes produce no response.
- A read immediately after a write to the same address returns the new data (macro write-first behaviour at N, read at N+1).
- sleep_req and req_valid in the same ACTIVE cycle: the request is accepted and the sleep transition waits one cycle.
- Reset mid-operation (any state, incl. WAKE or a pending read): state returns to ACTIVE and the pending rsp_valid is squashed. Array contents are not touched.

Decomposition:
- spram_pkg: state enum (ACTIVE, STBY, SLEEP, WAKE), constant SPRAM_AW=14, function be2mask.
- Sub-module spram_pwr_fsm: state, idle counter, wake counter; outputs stdby/sleep/ready_en.

Test Plan:
- Write addr 0x0010 data 0xDEADBEEF be=F, then read 0x0010 -> rsp_valid exactly 1 cycle after read accept, rsp_rdata=0xDEADBEEF.
- Write 0x11223344 be=F, then write 0xAABBCCDD be=0x5, read -> 0x11BB33DD; be=0 write -> data unchanged.
- BANKS=2: write 0x4000 (bank 1) and 0x0000 (bank 0) distinct values; read both back-to-back -> correct values on consecutive cycles, only one spram_cs bit high per cycle.
- Idle IDLE_CYCLES=4 -> stdby=1 on the 5th idle cycle. Then req_valid -> req_ready=0 for 1+WAKE_CYCLES cycles, then the request is accepted and read data is correct.
- sleep_req=1 while idle -> spram_sleep=1, req_ready=0. Deassert -> WAKE_CYCLES later req_ready=1; prior data is retained.
- Assert rst in the cycle after a read accept -> rsp_valid stays 0; after reset, req_ready=1 and stdby=sleep=0.
